// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per result producer, round-robin
// grant of one occupied slot per cycle onto a registered write-back broadcast.
module cdb_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int ROB_WIDTH = 4,
    parameter int SRC_WIDTH = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           rdy_in,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*ROB_WIDTH-1:0]   src_rob_id,
    input  logic [NUM_SRC*32-1:0]          src_data,
    input  logic [NUM_SRC-1:0]             src_set_jump_addr,
    output logic [NUM_SRC-1:0]             src_ready,
    output logic                           cdb_valid,
    output logic [ROB_WIDTH-1:0]           cdb_rob_id,
    output logic [31:0]                    cdb_data,
    output logic                           cdb_set_jump_addr,
    output logic [SRC_WIDTH-1:0]           cdb_src,
    output logic                           busy
);

    logic [NUM_SRC-1:0]   r_occ;
    logic [ROB_WIDTH-1:0] r_rob  [NUM_SRC];
    logic [31:0]          r_data [NUM_SRC];
    logic [NUM_SRC-1:0]   r_jump;
    logic [SRC_WIDTH-1:0] r_rr_ptr;

    logic                 w_adv;
    logic                 w_grant_en;
    logic [SRC_WIDTH-1:0] w_grant_idx;
    logic [SRC_WIDTH-1:0] w_next_ptr;
    logic [NUM_SRC-1:0]   w_gnt;
    logic [NUM_SRC-1:0]   w_take;
    logic [ROB_WIDTH-1:0] w_sel_rob;
    logic [31:0]          w_sel_data;
    logic                 w_sel_jump;

    assign w_adv = rdy_in && !flush;
    assign busy  = |r_occ;

    // Circular scan starting at the round-robin pointer; first occupied slot wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_en  = 1'b0;
        w_grant_idx = '0;
        w_gnt       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_SRC;
            if (!w_grant_en && r_occ[idx]) begin
                w_grant_en  = 1'b1;
                w_grant_idx = SRC_WIDTH'(idx);
                w_gnt[idx]  = 1'b1;
            end
        end
        w_next_ptr = SRC_WIDTH'((int'(w_grant_idx) + 1) % NUM_SRC);
    end

    always_comb begin
        w_sel_rob  = '0;
        w_sel_data = '0;
        w_sel_jump = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_gnt[i]) begin
                w_sel_rob  = r_rob[i];
                w_sel_data = r_data[i];
                w_sel_jump = r_jump[i];
            end
        end
    end

    // A slot being drained this cycle may be refilled on the same edge.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = w_adv && (!r_occ[i] || w_gnt[i]);
            w_take[i]    = src_valid[i] && src_ready[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_occ  <= '0;
            r_jump <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_rob[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (flush) begin
                    r_occ[i] <= 1'b0;
                end else if (w_take[i]) begin
                    r_occ[i]  <= 1'b1;
                    r_rob[i]  <= src_rob_id[i*ROB_WIDTH +: ROB_WIDTH];
                    r_data[i] <= src_data[i*32 +: 32];
                    r_jump[i] <= src_set_jump_addr[i];
                end else if (w_gnt[i]) begin
                    r_occ[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rr_ptr          <= '0;
            cdb_valid         <= 1'b0;
            cdb_rob_id        <= '0;
            cdb_data          <= '0;
            cdb_set_jump_addr <= 1'b0;
            cdb_src           <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_rr_ptr  <= '0;
                cdb_valid <= 1'b0;
            end else if (w_grant_en) begin
                r_rr_ptr          <= w_next_ptr;
                cdb_valid         <= 1'b1;
                cdb_rob_id        <= w_sel_rob;
                cdb_data          <= w_sel_data;
                cdb_set_jump_addr <= w_sel_jump;
                cdb_src           <= w_grant_idx;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: capture, round-robin drain, streaming,
// flush, stall, jump flag and asynchronous reset.
module tb_cdb_arbiter;

    localparam int NS = 4;
    localparam int RW = 4;
    localparam int SW = 2;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              rdy_in;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS*RW-1:0]  src_rob_id;
    logic [NS*32-1:0]  src_data;
    logic [NS-1:0]     src_set_jump_addr;
    logic [NS-1:0]     src_ready;
    logic              cdb_valid;
    logic [RW-1:0]     cdb_rob_id;
    logic [31:0]       cdb_data;
    logic              cdb_set_jump_addr;
    logic [SW-1:0]     cdb_src;
    logic              busy;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_SRC(NS), .ROB_WIDTH(RW), .SRC_WIDTH(SW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
        .src_valid(src_valid), .src_rob_id(src_rob_id), .src_data(src_data),
        .src_set_jump_addr(src_set_jump_addr), .src_ready(src_ready),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
        .cdb_set_jump_addr(cdb_set_jump_addr), .cdb_src(cdb_src), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input logic [RW-1:0] rob, input logic [31:0] d,
                           input logic [SW-1:0] s);
        chk({tag, "_valid"}, 32'(cdb_valid), 32'd1);
        chk({tag, "_rob"},   32'(cdb_rob_id), 32'(rob));
        chk({tag, "_data"},  cdb_data, d);
        chk({tag, "_src"},   32'(cdb_src), 32'(s));
    endtask

    task automatic set_src(input int i, input logic [RW-1:0] rob, input logic [31:0] d);
        src_rob_id[i*RW +: RW] = rob;
        src_data[i*32 +: 32]   = d;
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        src_valid = '0; src_rob_id = '0; src_data = '0; src_set_jump_addr = '0;
        #12;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_cdb_data", cdb_data, 32'd0);
        chk("rst_cdb_rob", 32'(cdb_rob_id), 32'd0);
        chk("rst_cdb_src", 32'(cdb_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'hF);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // single result, one-cycle capture-to-broadcast latency
        set_src(0, 4'd3, 32'h12345678);
        src_valid = 4'b0001;
        tick();
        src_valid = '0;
        chk("t1_busy_cap", 32'(busy), 32'd1);
        chk("t1_valid_cap", 32'(cdb_valid), 32'd0);
        tick();
        chk_cdb("t1_bc", 4'd3, 32'h12345678, 2'd0);
        chk("t1_busy_bc", 32'(busy), 32'd0);
        tick();
        chk("t1_pulse_end", 32'(cdb_valid), 32'd0);
        chk("t1_data_hold", cdb_data, 32'h12345678);

        // flush an idle arbiter to bring the pointer back to 0
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // all four contend
        for (int i = 0; i < NS; i++) set_src(i, RW'(i + 8), 32'hA0 + 32'(i));
        src_valid = 4'b1111;
        tick();
        src_valid = '0;
        chk("t2_ready0", 32'(src_ready), 32'b0001);
        chk("t2_valid0", 32'(cdb_valid), 32'd0);
        tick();
        chk_cdb("t2_g0", 4'd8, 32'hA0, 2'd0);
        chk("t2_ready1", 32'(src_ready), 32'b0011);
        tick();
        chk_cdb("t2_g1", 4'd9, 32'hA1, 2'd1);
        chk("t2_ready2", 32'(src_ready), 32'b0111);
        tick();
        chk_cdb("t2_g2", 4'd10, 32'hA2, 2'd2);
        chk("t2_busy2", 32'(busy), 32'd1);
        chk("t2_ready3", 32'(src_ready), 32'b1111);
        tick();
        chk_cdb("t2_g3", 4'd11, 32'hA3, 2'd3);
        chk("t2_busy3", 32'(busy), 32'd0);
        tick();
        chk("t2_idle", 32'(cdb_valid), 32'd0);

        // source 2 streams back-to-back
        set_src(2, 4'd1, 32'hB0);
        src_valid = 4'b0100;
        tick();
        chk("t3_valid0", 32'(cdb_valid), 32'd0);
        chk("t3_ready_a", 32'(src_ready[2]), 32'd1);
        set_src(2, 4'd2, 32'hB1);
        tick();
        chk_cdb("t3_b0", 4'd1, 32'hB0, 2'd2);
        chk("t3_ready_b", 32'(src_ready[2]), 32'd1);
        set_src(2, 4'd3, 32'hB2);
        tick();
        chk_cdb("t3_b1", 4'd2, 32'hB1, 2'd2);
        src_valid = '0;
        tick();
        chk_cdb("t3_b2", 4'd3, 32'hB2, 2'd2);
        tick();
        chk("t3_idle", 32'(cdb_valid), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);

        // flush drops held results and a same-edge capture
        set_src(1, 4'd4, 32'hC1);
        set_src(3, 4'd6, 32'hC3);
        src_valid = 4'b1010;
        tick();
        chk("t4_busy_pre", 32'(busy), 32'd1);
        set_src(0, 4'd7, 32'hC0);
        src_valid = 4'b0001;
        flush = 1'b1;
        #1;
        chk("t4_ready_flush", 32'(src_ready), 32'b0000);
        tick();
        flush = 1'b0;
        src_valid = '0;
        chk("t4_valid", 32'(cdb_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        tick();
        chk("t4_valid_a", 32'(cdb_valid), 32'd0);
        tick();
        chk("t4_valid_b", 32'(cdb_valid), 32'd0);

        // stall with a pending pulse and slot 2 still occupied
        set_src(0, 4'd12, 32'hD0);
        set_src(2, 4'd14, 32'hD2);
        src_valid = 4'b0101;
        tick();
        src_valid = '0;
        tick();
        chk_cdb("t5_d0", 4'd12, 32'hD0, 2'd0);
        rdy_in = 1'b0;
        #1;
        chk("t5_ready_stall", 32'(src_ready), 32'b0000);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_cdb("t5_frozen", 4'd12, 32'hD0, 2'd0);
            chk("t5_busy", 32'(busy), 32'd1);
        end
        rdy_in = 1'b1;
        tick();
        chk_cdb("t5_d2", 4'd14, 32'hD2, 2'd2);
        tick();
        chk("t5_idle", 32'(cdb_valid), 32'd0);

        // jump-address flag on source 1
        set_src(1, 4'd5, 32'h00001000);
        src_set_jump_addr = 4'b0010;
        src_valid = 4'b0010;
        tick();
        src_valid = '0;
        src_set_jump_addr = '0;
        tick();
        chk_cdb("t6_jmp", 4'd5, 32'h00001000, 2'd1);
        chk("t6_jflag", 32'(cdb_set_jump_addr), 32'd1);

        // asynchronous reset mid-stream
        set_src(0, 4'd2, 32'hE0);
        set_src(3, 4'd9, 32'hE3);
        src_valid = 4'b1001;
        tick();
        src_valid = '0;
        tick();
        chk("t7_pre_valid", 32'(cdb_valid), 32'd1);
        chk("t7_pre_busy", 32'(busy), 32'd1);
        #1;
        rst_n_in = 1'b0;
        #1;
        chk("t7_valid", 32'(cdb_valid), 32'd0);
        chk("t7_data", cdb_data, 32'd0);
        chk("t7_rob", 32'(cdb_rob_id), 32'd0);
        chk("t7_src", 32'(cdb_src), 32'd0);
        chk("t7_jflag", 32'(cdb_set_jump_addr), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        chk("t7_after", 32'(cdb_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single reorder-buffer write-back port (the common data bus, CDB) among NUM_SRC result producers: ALU reservation station, load/store buffer, branch unit, and so on.
- Each source has a one-entry holding slot. A round-robin arbiter grants one occupied slot per cycle and drives a registered CDB broadcast, which feeds the ROB update port and the operand-forwarding logic.
- Flush discards all in-flight results.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
ROB_WIDTH, 4, width of ROB entry id
SRC_WIDTH, 2, width of source index (clog2(NUM_SRC), minimum 1)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; when low all state holds
flush  input  1  misprediction flush; honoured only when rdy_in=1
src_valid  input  NUM_SRC  per-source result request
src_rob_id  input  NUM_SRC*ROB_WIDTH  per-source ROB id; source i at bits [i*ROB_WIDTH +: ROB_WIDTH]
src_data  input  NUM_SRC*32  per-source result value; source i at bits [i*32 +: 32]
src_set_jump_addr  input  NUM_SRC  data is a jump target, not a result
src_ready  output  NUM_SRC  slot can accept this cycle
cdb_valid  output  1  broadcast valid (one-cycle pulse per grant)
cdb_rob_id  output  ROB_WIDTH  broadcast ROB id
cdb_data  output  32  broadcast value
cdb_set_jump_addr  output  1  broadcast jump-address flag
cdb_src  output  SRC_WIDTH  index of the granted source
busy  output  1  any slot occupied

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - occ[*]=0; rr_ptr=0.
  - cdb_valid=0, cdb_rob_id=0, cdb_data=0, cdb_set_jump_addr=0, cdb_src=0.
  - Reset mid-operation silently drops held results.
- Per-slot state: occ[i], rob_id[i], data[i], jump[i].
- Grant (combinational):
  - Pick the first i with occ[i]=1, scanning circularly from rr_ptr: rr_ptr, rr_ptr+1, …, NUM_SRC-1, 0, ….
  - grant_en = OR of occ. grant_idx = that i.
- src_ready[i] = !occ[i] || (grant_en && grant_idx==i). A slot being drained can be refilled in the same cycle. src_ready is low while rdy_in=0 or flush=1.
- Capture: on an edge with rdy_in=1, flush=0 and src_valid[i] && src_ready[i], the slot is loaded with the source's rob_id, data and jump flag, and occ[i]<=1.
  - A source must hold src_valid and its payload until it sees src_ready=1.
- Broadcast (edge with rdy_in=1, flush=0):
  - If grant_en: cdb_valid<=1; cdb_* <= slot[grant_idx]; cdb_src<=grant_idx; occ[grant_idx]<=0 unless refilled the same edge; rr_ptr <= (grant_idx+1) mod NUM_SRC.
  - Else: cdb_valid<=0, cdb payload holds, rr_ptr holds.
- Latency:
  - A result captured at edge t broadcasts at edge t+1 if it wins arbitration.
  - With all slots contending, worst-case wait is NUM_SRC-1 extra cycles. No starvation.
- No backpressure from the ROB: each cdb_valid pulse is consumed in its cycle.
- Flush (flush=1 && rdy_in=1): occ[*]<=0, cdb_valid<=0, rr_ptr<=0. Same-edge captures are discarded. Flush with rdy_in=0 is ignored.
- rdy_in=0: every register holds, including cdb_valid, so a pending pulse stays asserted until rdy_in returns.
- busy = OR of occ (combinational).
- The block checks nothing about rob_id: two sources may target the same ROB id, and both are broadcast in grant order.

Test Plan:
- After reset, src_valid=0001 with rob_id=3, data=0x12345678 → cdb_valid=1 one cycle after capture, cdb_rob_id=3, cdb_data=0x12345678, cdb_src=0, then cdb_valid=0.
- All four sources valid on the same edge with data 0xA0..0xA3 and rr_ptr=0 → CDB emits sources 0,1,2,3 on four consecutive cycles, src_ready[i] low until slot i drains, busy drops after the last grant.
- Source 2 streams back-to-back while the others are idle → one broadcast per cycle, src_ready[2] stays 1 through same-cycle refill, no bubbles.
- Slots 1 and 3 occupied, flush=1 with rdy_in=1 → next cycle occ=0, cdb_valid=0, busy=0, neither result is ever broadcast; a source 0 request on the flush edge is dropped.
- rdy_in=0 for 3 cycles while cdb_valid=1 and slot 2 is occupied → outputs frozen, no capture or grant; slot 2 broadcasts the cycle after rdy_in returns to 1.
- src_set_jump_addr=1 on source 1 with data 0x00001000 → cdb_set_jump_addr=1, cdb_data=0x00001000. rst_n_in pulsed low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
